// File: rtl/rtc_bus_pkg.sv
// Shared types and sizing helpers for the RTC bus arbiter.
package rtc_bus_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // Width of a counter that must be able to hold the value TIMEOUT.
   function automatic int unsigned tmo_cnt_w(input int unsigned timeout);
      return (timeout == 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or after base.
module rr_priority_pick #(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] base,
   output logic [N-1:0]  win_oh_c,
   output logic [IW-1:0] win_idx_c,
   output logic          win_vld_c
);

   logic [IW-1:0] cand;

   always_comb begin
      win_oh_c  = '0;
      win_idx_c = '0;
      win_vld_c = 1'b0;
      cand      = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IW'((32'(base) + k) % N);
         if (!win_vld_c && req[cand]) begin
            win_vld_c      = 1'b1;
            win_idx_c      = cand;
            win_oh_c[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Owns the RTC address/data bus for N_CH requesters; one latched command per frame,
// ownership changes only at frame boundaries with a one-cycle idle gap.
module rtc_bus_arbiter
   import rtc_bus_pkg::*;
#(
   parameter int unsigned N_CH    = 4,
   parameter int unsigned AW      = ADDR_W,
   parameter int unsigned DW      = DATA_W,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_CH-1:0]      req,
   input  logic [N_CH*AW-1:0]   ch_addr,
   input  logic [N_CH*DW-1:0]   ch_wdata,
   input  logic [N_CH-1:0]      ch_wr,
   input  logic                 rr_mode,
   input  logic                 frame_done,
   input  logic [DW-1:0]        bus_rdata,
   output logic [AW-1:0]        bus_addr,
   output logic [DW-1:0]        bus_wdata,
   output logic                 bus_wr,
   output logic                 frame_start,
   output logic                 idle,
   output logic [N_CH-1:0]      grant,
   output logic [N_CH-1:0]      ack,
   output logic [DW-1:0]        rdata,
   output logic                 timeout_err
);

   localparam int unsigned IW = $clog2(N_CH);
   localparam int unsigned CW = tmo_cnt_w(TIMEOUT);

   state_e          state_q, state_d;
   logic [AW-1:0]   bus_addr_q, bus_addr_d;
   logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
   logic            bus_wr_q, bus_wr_d;
   logic            frame_start_q, frame_start_d;
   logic            idle_q, idle_d;
   logic [N_CH-1:0] grant_q, grant_d;
   logic [N_CH-1:0] ack_q, ack_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            timeout_err_q, timeout_err_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [N_CH-1:0] pick_oh;
   logic [IW-1:0]   pick_idx;
   logic            pick_vld;
   logic            tmo_hit;

   // Fixed priority is simply a rotation base of zero.
   rr_priority_pick #(.N(N_CH)) u_pick (
      .req       (req),
      .base      (rr_mode ? rr_ptr_q : '0),
      .win_oh_c  (pick_oh),
      .win_idx_c (pick_idx),
      .win_vld_c (pick_vld)
   );

   assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

   always_comb begin
      state_d       = state_q;
      bus_addr_d    = bus_addr_q;
      bus_wdata_d   = bus_wdata_q;
      bus_wr_d      = bus_wr_q;
      frame_start_d = 1'b0;
      grant_d       = grant_q;
      ack_d         = '0;
      rdata_d       = rdata_q;
      timeout_err_d = 1'b0;
      rr_ptr_d      = rr_ptr_q;
      cnt_d         = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               bus_addr_d    = ch_addr[32'(pick_idx) * AW +: AW];
               bus_wdata_d   = ch_wdata[32'(pick_idx) * DW +: DW];
               bus_wr_d      = ch_wr[pick_idx];
               grant_d       = pick_oh;
               frame_start_d = 1'b1;
               cnt_d         = '0;
               rr_ptr_d      = (pick_idx == IW'(N_CH - 1)) ? '0 : pick_idx + IW'(1);
               state_d       = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // A completed frame takes precedence over a simultaneous timeout.
            if (frame_done) begin
               if (!bus_wr_q) rdata_d = bus_rdata;
               ack_d   = grant_q;
               grant_d = '0;
               state_d = ST_GAP;
            end else if (tmo_hit) begin
               timeout_err_d = 1'b1;
               grant_d       = '0;
               state_d       = ST_GAP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      idle_d = (state_d != ST_BUSY);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         bus_addr_q    <= '0;
         bus_wdata_q   <= '0;
         bus_wr_q      <= 1'b0;
         frame_start_q <= 1'b0;
         idle_q        <= 1'b1;
         grant_q       <= '0;
         ack_q         <= '0;
         rdata_q       <= '0;
         timeout_err_q <= 1'b0;
         rr_ptr_q      <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         bus_addr_q    <= bus_addr_d;
         bus_wdata_q   <= bus_wdata_d;
         bus_wr_q      <= bus_wr_d;
         frame_start_q <= frame_start_d;
         idle_q        <= idle_d;
         grant_q       <= grant_d;
         ack_q         <= ack_d;
         rdata_q       <= rdata_d;
         timeout_err_q <= timeout_err_d;
         rr_ptr_q      <= rr_ptr_d;
         cnt_q         <= cnt_d;
      end
   end

   assign bus_addr    = bus_addr_q;
   assign bus_wdata   = bus_wdata_q;
   assign bus_wr      = bus_wr_q;
   assign frame_start = frame_start_q;
   assign idle        = idle_q;
   assign grant       = grant_q;
   assign ack         = ack_q;
   assign rdata       = rdata_q;
   assign timeout_err = timeout_err_q;

endmodule
